// File: rtl/comp_mult_pipe.sv
// Fully pipelined signed complex multiplier with optional conjugate of the
// second operand. Full-precision result, credit-controlled output FIFO.
// Stages: S1 operand regs -> S2 product regs -> S3 add/sub into FIFO.
module comp_mult_pipe #(
    parameter int DWIDTH     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sw_rst,
    input  logic                          op_val,
    output logic                          op_rdy,
    input  logic [4*DWIDTH-1:0]           op_data,
    input  logic                          op_conj,
    output logic                          res_val,
    input  logic                          res_rdy,
    output logic [2*(2*DWIDTH+1)-1:0]     res_data
);

    localparam int PW = 2*DWIDTH;
    localparam int RW = 2*DWIDTH + 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(FIFO_DEPTH - 1);

    // Pipeline valids
    logic              v1_q, v1_d, v2_q, v2_d;
    // S1 operand regs
    logic [4*DWIDTH-1:0] opd_q, opd_d;
    logic              cj1_q, cj1_d;
    // S2 product regs
    logic signed [PW-1:0] pxx_q, pyy_q, pxy_q, pyx_q;
    logic signed [PW-1:0] pxx_d, pyy_d, pxy_d, pyx_d;
    logic              cj2_q, cj2_d;
    // FIFO and credit state
    logic [2*RW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d, occ_q, occ_d;

    logic              accept, pop, push;
    logic [RW-1:0]     xr, yr;

    // Sign-extend a component to product width so the multiply is exact.
    function automatic logic signed [PW-1:0] sx(input logic [DWIDTH-1:0] a);
        return signed'({{DWIDTH{a[DWIDTH-1]}}, a});
    endfunction

    // Sign-extend a product to result width so add/sub cannot wrap.
    function automatic logic [RW-1:0] px(input logic signed [PW-1:0] p);
        return {p[PW-1], p};
    endfunction

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == LAST_C) ? '0 : p + AW'(1);
    endfunction

    assign op_rdy  = (occ_q < DEPTH_C) & ~sw_rst;
    assign accept  = op_val & op_rdy;
    assign res_val = (cnt_q != '0);
    assign pop     = res_val & res_rdy;
    assign push    = v2_q;
    assign res_data = res_val ? mem_q[rd_ptr_q] : '0;

    // S3 add/sub; conj flips the sign of y2, swapping which cross terms subtract
    always_comb begin
        if (cj2_q) begin
            xr = px(pxx_q) + px(pyy_q);
            yr = px(pyx_q) - px(pxy_q);
        end else begin
            xr = px(pxx_q) - px(pyy_q);
            yr = px(pxy_q) + px(pyx_q);
        end
    end

    // Datapath next-state: capture operands on accept, products when S1 valid
    always_comb begin
        opd_d = opd_q;
        cj1_d = cj1_q;
        pxx_d = pxx_q;
        pyy_d = pyy_q;
        pxy_d = pxy_q;
        pyx_d = pyx_q;
        cj2_d = cj2_q;
        if (accept) begin
            opd_d = op_data;
            cj1_d = op_conj;
        end
        if (v1_q) begin
            pxx_d = sx(opd_q[4*DWIDTH-1 -: DWIDTH]) * sx(opd_q[2*DWIDTH-1 -: DWIDTH]);
            pyy_d = sx(opd_q[3*DWIDTH-1 -: DWIDTH]) * sx(opd_q[DWIDTH-1:0]);
            pxy_d = sx(opd_q[4*DWIDTH-1 -: DWIDTH]) * sx(opd_q[DWIDTH-1:0]);
            pyx_d = sx(opd_q[3*DWIDTH-1 -: DWIDTH]) * sx(opd_q[2*DWIDTH-1 -: DWIDTH]);
            cj2_d = cj1_q;
        end
    end

    // Control next-state: valids, FIFO pointers/level, credit counter
    always_comb begin
        v1_d     = accept;
        v2_d     = v1_q;
        wr_ptr_d = push ? inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
        occ_d    = occ_q;
        if (accept && !pop)      occ_d = occ_q + CW'(1);
        else if (!accept && pop) occ_d = occ_q - CW'(1);
        if (sw_rst) begin
            v1_d     = 1'b0;
            v2_d     = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            occ_d    = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            occ_q    <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            occ_q    <= occ_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opd_q <= '0;
            cj1_q <= 1'b0;
            pxx_q <= '0;
            pyy_q <= '0;
            pxy_q <= '0;
            pyx_q <= '0;
            cj2_q <= 1'b0;
        end else begin
            opd_q <= opd_d;
            cj1_q <= cj1_d;
            pxx_q <= pxx_d;
            pyy_q <= pyy_d;
            pxy_q <= pxy_d;
            pyx_q <= pyx_d;
            cj2_q <= cj2_d;
        end
    end

    // FIFO storage; contents are qualified by the level, so no reset needed
    always_ff @(posedge clk) begin
        if (push && !sw_rst) mem_q[wr_ptr_q] <= {xr, yr};
    end

endmodule

// File: tb/tb_comp_mult_pipe.sv
// Directed/random bench for comp_mult_pipe with a scoreboard queue.
module tb_comp_mult_pipe;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int RW = 2*DW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sw_rst = 1'b0;
    logic              op_val = 1'b0;
    logic              op_rdy;
    logic [4*DW-1:0]   op_data = '0;
    logic              op_conj = 1'b0;
    logic              res_val;
    logic              res_rdy = 1'b0;
    logic [2*RW-1:0]   res_data;

    comp_mult_pipe #(.DWIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
        .op_val(op_val), .op_rdy(op_rdy), .op_data(op_data), .op_conj(op_conj),
        .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2*RW-1:0] d; int c; } exp_t;
    exp_t            q[$];
    logic [2*RW-1:0] nxt_exp = '0;
    bit              lat_chk = 1'b0;
    int              cyc = 0;
    int              n_vec = 0;
    int              n_err = 0;
    int              n_pop = 0;
    logic            hold = 1'b0;
    logic [2*RW-1:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*RW-1:0] model(input logic signed [DW-1:0] x1, y1, x2, y2,
                                              input bit cj);
        int a, b, c, d, xr, yr;
        logic [RW-1:0] xv, yv;
        a = int'(x1); b = int'(y1); c = int'(x2); d = int'(y2);
        xr = cj ? (a*c + b*d) : (a*c - b*d);
        yr = cj ? (b*c - a*d) : (a*d + b*c);
        xv = xr[RW-1:0];
        yv = yr[RW-1:0];
        return {xv, yv};
    endfunction

    // Drive one op and hold it until accepted (bounded)
    task automatic send(input logic signed [DW-1:0] x1, y1, x2, y2, input bit cj,
                        input logic [2*RW-1:0] e, input bit must_rdy);
        bit ok;
        ok = 1'b0;
        op_data = {x1, y1, x2, y2};
        op_conj = cj;
        nxt_exp = e;
        op_val  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (must_rdy && i == 0) chk("stream_op_rdy", 64'(op_rdy), 64'd1);
            if (op_rdy) begin ok = 1'b1; break; end
        end
        chk("send_accepted", 64'(ok), 64'd1);
        @(posedge clk); #1;
        op_val = 1'b0;
    endtask

    task automatic send_rand(input bit must_rdy);
        logic signed [DW-1:0] r0, r1, r2, r3;
        bit cj;
        r0 = DW'($urandom); r1 = DW'($urandom);
        r2 = DW'($urandom); r3 = DW'($urandom);
        cj = 1'($urandom);
        send(r0, r1, r2, r3, cj, model(r0, r1, r2, r3, cj), must_rdy);
    endtask

    // Scoreboard push on accept
    always @(negedge clk) begin
        if (rst_n && op_val && op_rdy) q.push_back('{nxt_exp, cyc});
    end

    // Scoreboard pop/compare, result stability and FIFO overflow checks
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_val && res_rdy) begin
            if (q.size() == 0) begin
                chk("spurious_result", 64'(res_data), 64'd0);
                chk("spurious_valid", 64'(res_val), 64'd0);
            end else begin
                e = q.pop_front();
                chk("res_data", 64'(res_data), 64'(e.d));
                if (lat_chk) chk("latency", 64'(cyc), 64'(e.c + 3));
            end
            n_pop++;
        end
        if (rst_n && hold && res_val) chk("res_hold", 64'(res_data), 64'(held));
        hold <= rst_n && res_val && !res_rdy && !sw_rst;
        held <= res_data;
        assert (!(rst_n && dut.push && dut.cnt_q == FD && !dut.pop)) else begin
            n_err++;
            $error("FAIL push_full: push into full FIFO at cycle %0d", cyc);
        end
    end

    initial begin
        int acc, pops0;
        res_rdy = 1'b1;
        #2;
        chk("rst_res_val", 64'(res_val), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_op_rdy", 64'(op_rdy), 64'd1);

        // Basic, conjugate and extremes, latency checked
        @(posedge clk); #1;
        lat_chk = 1'b1;
        send(8'sd3, 8'sd4, 8'sd1, 8'sd2, 1'b0, {17'h1FFFB, 17'h0000A}, 1'b1);
        repeat (4) @(negedge clk);
        chk("basic_val_after", 64'(res_val), 64'd0);
        @(posedge clk); #1;
        send(8'sd3, 8'sd4, 8'sd1, 8'sd2, 1'b1, {17'd11, 17'h1FFFE}, 1'b1);
        send(8'h80, 8'h80, 8'h80, 8'h80, 1'b0, {17'h00000, 17'h08000}, 1'b1);
        send(8'h80, 8'h80, 8'h80, 8'h80, 1'b1, {17'h08000, 17'h00000}, 1'b1);
        repeat (5) @(negedge clk);
        chk("directed_drained", 64'(q.size()), 64'd0);

        // Streaming 16 back-to-back
        @(posedge clk); #1;
        pops0 = n_pop;
        for (int i = 0; i < 16; i++) send_rand(1'b1);
        repeat (5) @(negedge clk);
        chk("stream_count", 64'(n_pop - pops0), 64'd16);
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Backpressure: op_val held high, res_rdy low
        lat_chk = 1'b0;
        @(posedge clk); #1;
        res_rdy = 1'b0;
        pops0 = n_pop;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            logic signed [DW-1:0] a0, a1, a2, a3;
            a0 = DW'($urandom); a1 = DW'($urandom); a2 = DW'($urandom); a3 = DW'($urandom);
            op_data = {a0, a1, a2, a3};
            op_conj = 1'b0;
            nxt_exp = model(a0, a1, a2, a3, 1'b0);
            op_val  = 1'b1;
            @(negedge clk);
            if (op_rdy) acc++;
            @(posedge clk); #1;
        end
        chk("bp_accepts", 64'(acc), 64'(FD));
        chk("bp_op_rdy_low", 64'(op_rdy), 64'd0);
        op_val  = 1'b0;
        res_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_op_rdy_after_pop", 64'(op_rdy), 64'd1);
        repeat (8) @(negedge clk);
        chk("bp_count", 64'(n_pop - pops0), 64'(FD));
        chk("bp_drained", 64'(q.size()), 64'd0);

        // sw_rst with 3 in flight
        @(posedge clk); #1;
        res_rdy = 1'b0;
        pops0 = n_pop;
        for (int i = 0; i < 3; i++) send_rand(1'b0);
        sw_rst = 1'b1;
        @(negedge clk);
        chk("swrst_op_rdy_low", 64'(op_rdy), 64'd0);
        @(posedge clk); #1;
        sw_rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("swrst_res_val", 64'(res_val), 64'd0);
        chk("swrst_op_rdy", 64'(op_rdy), 64'd1);
        res_rdy = 1'b1;
        repeat (6) @(negedge clk);
        chk("swrst_no_results", 64'(n_pop - pops0), 64'd0);

        // rst_n asserted mid-cycle with results queued
        @(posedge clk); #1;
        res_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send_rand(1'b0);
        repeat (2) @(posedge clk);
        #1 chk("pre_rst_res_val", 64'(res_val), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_res_val", 64'(res_val), 64'd0);
        chk("async_rst_res_data", 64'(res_data), 64'd0);
        q.delete();
        pops0 = n_pop;
        @(posedge clk); #3 rst_n = 1'b1;
        res_rdy = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_results", 64'(n_pop - pops0), 64'd0);
        chk("rst_op_rdy_after", 64'(op_rdy), 64'd1);

        // Recovery after reset
        @(posedge clk); #1;
        lat_chk = 1'b1;
        send(8'sd3, 8'sd4, 8'sd1, 8'sd2, 1'b0, {17'h1FFFB, 17'h0000A}, 1'b1);
        repeat (5) @(negedge clk);
        chk("final_drained", 64'(q.size()), 64'd0);
        chk("final_pop", 64'(n_pop - pops0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
